// File: rtl/ram_block_mover.sv
// Block copy / constant fill engine driving two single-port clocked-read RAMs.
// Reads run one ce ahead of writes, so one word moves per ce once the pipe is full.
module ram_block_mover #(
    parameter int DATA = 8,
    parameter int ADDR = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ce,
    input  logic            start,
    input  logic            abort,
    input  logic            fill,
    input  logic [DATA-1:0] fill_val,
    input  logic [ADDR-1:0] src_base,
    input  logic [ADDR-1:0] dst_base,
    input  logic [ADDR:0]   len,
    output logic            busy,
    output logic            done,
    output logic            src_ce,
    output logic [ADDR-1:0] src_addr,
    input  logic [DATA-1:0] src_dout,
    output logic            dst_ce,
    output logic            dst_wr,
    output logic [ADDR-1:0] dst_addr,
    output logic [DATA-1:0] dst_din
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [ADDR:0] DEPTH = {1'b1, {ADDR{1'b0}}};

    state_t          state;
    logic [ADDR:0]   rd_left;
    logic            fill_q;
    logic [DATA-1:0] fill_val_q;
    logic [ADDR:0]   len_eff;

    assign len_eff = (len > DEPTH) ? DEPTH : len;
    assign src_ce  = ce;
    assign dst_ce  = ce;
    assign dst_din = fill_q ? fill_val_q : src_dout;

    // done is cleared on every clk so it stays a single-clk pulse even when ce is sparse;
    // abort bypasses ce and wins over a simultaneous start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            dst_wr     <= 1'b0;
            src_addr   <= '0;
            dst_addr   <= '0;
            rd_left    <= '0;
            fill_q     <= 1'b0;
            fill_val_q <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state  <= IDLE;
                busy   <= 1'b0;
                dst_wr <= 1'b0;
            end else if (ce) begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            fill_q     <= fill;
                            fill_val_q <= fill_val;
                            src_addr   <= src_base;
                            dst_addr   <= dst_base;
                            rd_left    <= len_eff;
                            dst_wr     <= 1'b0;
                            if (len_eff == '0) begin
                                done <= 1'b1;
                            end else begin
                                state <= RUN;
                                busy  <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (rd_left != '0) begin
                            src_addr <= src_addr + 1'b1;
                            rd_left  <= rd_left - 1'b1;
                            dst_wr   <= 1'b1;
                        end else begin
                            dst_wr <= 1'b0;
                        end
                        if (dst_wr) begin
                            dst_addr <= dst_addr + 1'b1;
                        end
                        // Last write commits on this edge: nothing left to read.
                        if (dst_wr && (rd_left == '0)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ram_block_mover.sv
// Self-checking bench for ram_block_mover with behavioural source and destination RAMs.
module tb_ram_block_mover;

    localparam int DATA  = 8;
    localparam int ADDR  = 10;
    localparam int DEPTH = 1024;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            ce = 1'b1;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic            fill = 1'b0;
    logic [DATA-1:0] fill_val = '0;
    logic [ADDR-1:0] src_base = '0;
    logic [ADDR-1:0] dst_base = '0;
    logic [ADDR:0]   len = '0;
    logic            busy, done, src_ce, dst_ce, dst_wr;
    logic [ADDR-1:0] src_addr, dst_addr;
    logic [DATA-1:0] src_dout = '0;
    logic [DATA-1:0] dst_din;

    logic [DATA-1:0] src_mem [DEPTH];
    logic [DATA-1:0] dst_mem [DEPTH];
    logic [DATA-1:0] exp_dst [DEPTH];
    logic            ram_init = 1'b1;

    bit ce_mode = 1'b0;
    int ce_phase = 0;
    int ce_edges = 0;
    int wr_total = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic            fill;
        logic [DATA-1:0] fill_val;
        logic [ADDR-1:0] src_base;
        logic [ADDR-1:0] dst_base;
        logic [ADDR:0]   len;
        int              exp_lat;
        logic [ADDR-1:0] exp_src_end;
        logic [ADDR-1:0] exp_dst_end;
        int              exp_writes;
    } vec_t;

    vec_t vecs [5];

    ram_block_mover #(.DATA(DATA), .ADDR(ADDR)) dut (
        .clk(clk), .reset(reset), .ce(ce), .start(start), .abort(abort),
        .fill(fill), .fill_val(fill_val), .src_base(src_base), .dst_base(dst_base),
        .len(len), .busy(busy), .done(done), .src_ce(src_ce), .src_addr(src_addr),
        .src_dout(src_dout), .dst_ce(dst_ce), .dst_wr(dst_wr), .dst_addr(dst_addr),
        .dst_din(dst_din)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA-1:0] init_pat(input int i);
        return DATA'((i * 7 + 3) & 8'hFF);
    endfunction

    always @(negedge clk) begin
        if (ce_mode) begin
            ce_phase = (ce_phase == 2) ? 0 : ce_phase + 1;
            ce = (ce_phase == 0);
        end else begin
            ce = 1'b1;
        end
    end

    always @(posedge clk) begin
        if (src_ce) src_dout <= src_mem[src_addr];
    end

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < DEPTH; i++) dst_mem[i] <= init_pat(i);
        end else if (dst_ce && dst_wr) begin
            dst_mem[dst_addr] <= dst_din;
        end
    end

    always @(posedge clk) begin
        if (ce) ce_edges <= ce_edges + 1;
        if (dst_ce && dst_wr) wr_total <= wr_total + 1;
    end

    task automatic checkOutput(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s: actual %0d (0x%0h) required %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    task automatic compareImage(input string name);
        int bad = 0;
        int first = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (dst_mem[i] !== exp_dst[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL %s: %0d dst words wrong, first at 0x%0h actual 0x%0h required 0x%0h",
                     name, bad, first, dst_mem[first], exp_dst[first]);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input bit toggle, input string name);
        int accept_ce, wr0, n;
        bit got, unstable;
        logic [2*ADDR+1:0] prev, cur;
        logic [ADDR-1:0] sa, da;

        @(negedge clk);
        ce_mode  = toggle;
        fill     = v.fill;
        fill_val = v.fill_val;
        src_base = v.src_base;
        dst_base = v.dst_base;
        len      = v.len;
        wr0      = wr_total;
        start    = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(posedge clk); #1;
            if (busy || done) got = 1'b1;
        end
        checkOutput({name, " accept"}, int'(got), 1);
        accept_ce = ce_edges;
        if (v.len == 0) begin
            checkOutput({name, " len0 done"}, int'(done), 1);
            checkOutput({name, " len0 busy"}, int'(busy), 0);
        end else begin
            checkOutput({name, " busy at accept"}, int'(busy), 1);
            checkOutput({name, " dst_wr at accept"}, int'(dst_wr), 0);
        end
        @(negedge clk);
        start = 1'b0;

        if (v.len != 0) begin
            got = 1'b0;
            unstable = 1'b0;
            prev = {busy, dst_wr, src_addr, dst_addr};
            for (int c = 0; c < 4000 && !got; c++) begin
                @(posedge clk); #1;
                cur = {busy, dst_wr, src_addr, dst_addr};
                if (!ce && cur != prev) unstable = 1'b1;
                prev = cur;
                if (done) got = 1'b1;
            end
            checkOutput({name, " done seen"}, int'(got), 1);
            checkOutput({name, " latency"}, ce_edges - accept_ce, v.exp_lat);
            checkOutput({name, " busy at done"}, int'(busy), 0);
            checkOutput({name, " hold on non-ce"}, int'(unstable), 0);
        end
        @(posedge clk); #1;
        checkOutput({name, " done one clk"}, int'(done), 0);
        checkOutput({name, " src_addr end"}, int'(src_addr), int'(v.exp_src_end));
        checkOutput({name, " dst_addr end"}, int'(dst_addr), int'(v.exp_dst_end));
        checkOutput({name, " writes"}, wr_total - wr0, v.exp_writes);

        n = (v.len > 11'd1024) ? 1024 : int'(v.len);
        sa = v.src_base;
        da = v.dst_base;
        for (int k = 0; k < n; k++) begin
            exp_dst[da] = v.fill ? v.fill_val : src_mem[sa];
            sa = sa + 1'b1;
            da = da + 1'b1;
        end
        compareImage({name, " contents"});
        ce_mode = 1'b0;
    endtask

    initial begin
        int wr0;
        bit got;
        vec_t tog, post;

        for (int i = 0; i < DEPTH; i++) begin
            src_mem[i] = DATA'((i ^ 8'hC6) & 8'hFF);
            exp_dst[i] = init_pat(i);
        end
        src_mem[10'h010] = 8'hA1;
        src_mem[10'h011] = 8'hB2;
        src_mem[10'h012] = 8'hC3;
        src_mem[10'h013] = 8'hD4;

        vecs[0] = '{1'b0, 8'h00, 10'h010, 10'h200, 11'd4,    5,    10'h014, 10'h204, 4};
        vecs[1] = '{1'b1, 8'h00, 10'h123, 10'h000, 11'd1024, 1025, 10'h123, 10'h000, 1024};
        vecs[2] = '{1'b0, 8'h00, 10'h3FE, 10'h3FF, 11'd3,    4,    10'h001, 10'h002, 3};
        vecs[3] = '{1'b0, 8'h00, 10'h055, 10'h066, 11'd0,    0,    10'h055, 10'h066, 0};
        vecs[4] = '{1'b1, 8'hA5, 10'h000, 10'h100, 11'd2000, 1025, 10'h000, 10'h100, 1024};

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset done", int'(done), 0);
        checkOutput("reset dst_wr", int'(dst_wr), 0);
        checkOutput("reset src_addr", int'(src_addr), 0);
        checkOutput("reset dst_addr", int'(dst_addr), 0);
        @(negedge clk);
        ram_init = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i], 1'b0, $sformatf("vec%0d", i));
        end

        tog = '{1'b0, 8'h00, 10'h010, 10'h080, 11'd3, 4, 10'h013, 10'h083, 3};
        applyStimulus(tog, 1'b1, "ce 1of3");

        @(negedge clk);
        fill = 1'b0;
        src_base = 10'h040;
        dst_base = 10'h300;
        len = 11'd8;
        wr0 = wr_total;
        start = 1'b1;
        @(posedge clk); #1;
        checkOutput("abort busy at accept", int'(busy), 1);
        @(negedge clk);
        start = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(posedge clk); #1;
            if (wr_total - wr0 == 1) got = 1'b1;
        end
        checkOutput("abort first write", int'(got), 1);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk); #1;
        checkOutput("abort busy", int'(busy), 0);
        checkOutput("abort dst_wr", int'(dst_wr), 0);
        checkOutput("abort done", int'(done), 0);
        checkOutput("abort src_addr", int'(src_addr), 10'h042);
        checkOutput("abort dst_addr", int'(dst_addr), 10'h301);
        @(negedge clk);
        abort = 1'b0;
        got = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done || busy) got = 1'b1;
        end
        checkOutput("abort no done", int'(got), 0);
        checkOutput("abort writes", wr_total - wr0, 2);
        exp_dst[10'h300] = src_mem[10'h040];
        exp_dst[10'h301] = src_mem[10'h041];
        compareImage("abort contents");

        @(negedge clk);
        src_base = 10'h1AA;
        dst_base = 10'h0AA;
        len = 11'd5;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        checkOutput("start+abort busy", int'(busy), 0);
        checkOutput("start+abort done", int'(done), 0);
        checkOutput("start+abort src_addr", int'(src_addr), 10'h042);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;

        post = '{1'b0, 8'h00, 10'h020, 10'h050, 11'd1, 2, 10'h021, 10'h051, 1};
        applyStimulus(post, 1'b0, "post-abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
